// File: rtl/conv_fir_ci_pkg.sv
// Shared types and the rounding/saturation helper for the FIR custom instruction.
package conv_ci_pkg;

  typedef enum logic [1:0] {
    OP_FILTER    = 2'd0,
    OP_LOAD_COEF = 2'd1,
    OP_CLEAR     = 2'd2,
    OP_READ_TAP  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAC   = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Round half up, arithmetic shift right, then clamp to a signed 'width'-bit
  // range. The accumulator is passed pre-sign-extended to 64 bits so one
  // function serves any ACC_W up to 64.
  function automatic logic signed [31:0] sat_round(input logic signed [63:0] acc,
                                                   input int shift,
                                                   input int width);
    logic signed [63:0] r, hi, lo;
    r  = (shift > 0) ? acc + (64'sd1 <<< (shift - 1)) : acc;
    r  = r >>> shift;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (r > hi)      r = hi;
    else if (r < lo) r = lo;
    return 32'(r);
  endfunction

endpackage

// File: rtl/conv_fir_ci_if.sv
// Nios II custom-instruction port bundle (clock enable, handshake, operands, result).
interface conv_fir_ci_if;
  logic        clk_en;
  logic        start;
  logic [1:0]  n;
  logic [31:0] dataa;
  logic [31:0] datab;
  logic [31:0] result;
  logic        done;

  modport master (output clk_en, start, n, dataa, datab, input result, done);
  modport slave  (input clk_en, start, n, dataa, datab, output result, done);
endinterface

// File: rtl/conv_fir_ci_mac.sv
// Registered signed multiply-accumulate: acc += sample*coef when enabled.
module conv_mac_unit #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int ACC_W  = 40
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr_i,
  input  logic                     en_i,
  input  logic signed [DATA_W-1:0] sample_i,
  input  logic signed [COEF_W-1:0] coef_i,
  output logic signed [ACC_W-1:0]  acc_o
);
  localparam int PW = DATA_W + COEF_W;

  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] acc_q, acc_d;

  // Full-precision product, sign-extended into the accumulator width.
  assign prod  = PW'(sample_i) * PW'(coef_i);
  assign acc_d = acc_q + ACC_W'(prod);
  assign acc_o = acc_q;

  // Accumulator register; clear wins over accumulate.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      acc_q <= '0;
    else if (clr_i) acc_q <= '0;
    else if (en_i)  acc_q <= acc_d;
  end
endmodule

// File: rtl/conv_fir_ci.sv
// FIR convolution custom instruction: delay line, coefficient store, opcode
// decode and sequencing FSM around a single shared MAC.
module conv_fir_ci
  import conv_ci_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int TAPS      = 32,
  parameter int ACC_W     = 40,
  parameter int OUT_SHIFT = 15
) (
  input  logic        clk,
  input  logic        reset,
  conv_fir_ci_if.slave ci
);
  localparam int IDX_W = (TAPS > 1) ? $clog2(TAPS) : 1;

  state_e                   state_q, state_d;
  logic [IDX_W-1:0]         cnt_q, cnt_d;
  logic [31:0]              result_q, result_d;
  logic signed [DATA_W-1:0] tap_q  [TAPS];
  logic signed [COEF_W-1:0] coef_q [TAPS];
  logic signed [ACC_W-1:0]  acc;
  logic [IDX_W-1:0]         idx;
  op_e                      op;
  logic shift_en, clr_taps, coef_we, mac_clr, mac_en;
  logic unused_bits;

  // Index is taken modulo TAPS simply by dropping the upper datab bits.
  assign idx         = ci.datab[IDX_W-1:0];
  assign op          = op_e'(ci.n);
  assign unused_bits = ^{ci.dataa, ci.datab};

  // Next-state and datapath control; every output defaulted first.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    shift_en = 1'b0;
    clr_taps = 1'b0;
    coef_we  = 1'b0;
    mac_clr  = 1'b0;
    mac_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ci.start) begin
          case (op)
            OP_FILTER: begin
              shift_en = 1'b1;
              mac_clr  = 1'b1;
              cnt_d    = '0;
              state_d  = ST_MAC;
            end
            OP_LOAD_COEF: begin
              coef_we  = 1'b1;
              result_d = '0;
              state_d  = ST_DONE;
            end
            OP_CLEAR: begin
              clr_taps = 1'b1;
              result_d = '0;
              state_d  = ST_DONE;
            end
            default: begin
              result_d = 32'(tap_q[idx]);
              state_d  = ST_DONE;
            end
          endcase
        end
      end
      ST_MAC: begin
        mac_en = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == IDX_W'(TAPS - 1)) state_d = ST_ROUND;
      end
      ST_ROUND: begin
        result_d = sat_round(64'(acc), OUT_SHIFT, DATA_W);
        state_d  = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM, tap counter and result register; frozen while clk_en is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
    end else if (ci.clk_en) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  // Delay line: newest sample enters at tap 0, oldest falls off the end.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++) tap_q[i] <= '0;
    end else if (ci.clk_en) begin
      if (clr_taps) begin
        for (int i = 0; i < TAPS; i++) tap_q[i] <= '0;
      end else if (shift_en) begin
        tap_q[0] <= ci.dataa[DATA_W-1:0];
        for (int i = 1; i < TAPS; i++) tap_q[i] <= tap_q[i-1];
      end
    end
  end

  // Coefficient store, written one entry per LOAD_COEF.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++) coef_q[i] <= '0;
    end else if (ci.clk_en && coef_we) begin
      coef_q[idx] <= ci.dataa[COEF_W-1:0];
    end
  end

  conv_mac_unit #(.DATA_W(DATA_W), .COEF_W(COEF_W), .ACC_W(ACC_W)) u_mac (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (ci.clk_en & mac_clr),
    .en_i     (ci.clk_en & mac_en),
    .sample_i (tap_q[cnt_q]),
    .coef_i   (coef_q[cnt_q]),
    .acc_o    (acc)
  );

  // done is masked by clk_en so a stalled DONE cycle never reports twice.
  assign ci.result = result_q;
  assign ci.done   = ci.clk_en & (state_q == ST_DONE);
endmodule

// File: tb/tb_conv_fir_ci.sv
// Bench for conv_fir_ci: table of vectors plus hand sequences, scoreboard queue.
module tb_conv_fir_ci;
  import conv_ci_pkg::*;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  logic clk, reset;
  conv_fir_ci_if ci();

  conv_fir_ci dut (.clk(clk), .reset(reset), .ci(ci));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_chk, n_pass;
  logic [31:0] sb[$];
  shortint     m_tap[32];
  shortint     m_coef[32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) begin m_tap[i] = 0; m_coef[i] = 0; end
  endfunction

  // Behavioural reference: returns the value the instruction should produce.
  function automatic logic [31:0] model_apply(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
    longint acc;
    case (op)
      2'd0: begin
        for (int i = 31; i > 0; i--) m_tap[i] = m_tap[i-1];
        m_tap[0] = shortint'(a[15:0]);
        acc = 0;
        for (int k = 0; k < 32; k++) acc += longint'(m_tap[k]) * longint'(m_coef[k]);
        acc = (acc + 16384) >>> 15;
        if (acc > 32767) acc = 32767;
        if (acc < -32768) acc = -32768;
        return 32'(acc);
      end
      2'd1: begin m_coef[b[4:0]] = shortint'(a[15:0]); return 32'd0; end
      2'd2: begin for (int i = 0; i < 32; i++) m_tap[i] = 0; return 32'd0; end
      default: return 32'(int'(m_tap[b[4:0]]));
    endcase
  endfunction

  task automatic idle(input int cycles);
    int bad;
    bad = 0;
    repeat (cycles) begin
      @(negedge clk); #1;
      if (ci.done) bad++;
    end
    chk("no_stray_done", 32'(bad), 32'd0);
  endtask

  // Issue one instruction and wait (bounded) for done. Optional stall window,
  // a busy-time CLEAR start that must be ignored, or a reset mid-operation.
  task automatic issue(input string name, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input bit use_model,
                       input int lat, output logic [31:0] got, input int stall_at,
                       input int stall_len, input int busy_at, input int abort_at);
    logic [31:0] e, m;
    int cyc;
    bit ok, aborted;
    got = '0;
    @(negedge clk);
    m = model_apply(op, a, b);
    e = use_model ? m : exp;
    ci.n = op; ci.dataa = a; ci.datab = b; ci.start = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    ci.start = 1'b0;
    cyc = 1; ok = 0; aborted = 0;
    while (cyc < 300) begin
      if (cyc == abort_at) begin aborted = 1; break; end
      if (cyc == stall_at) ci.clk_en = 1'b0;
      if (cyc == stall_at + stall_len) ci.clk_en = 1'b1;
      if (cyc == busy_at) begin ci.n = OP_CLEAR; ci.start = 1'b1; end
      else ci.start = 1'b0;
      #1;
      if (ci.done) begin ok = 1; break; end
      @(negedge clk);
      cyc++;
    end
    ci.start = 1'b0;
    ci.clk_en = 1'b1;
    if (aborted) begin
      reset = 1'b1;
      #1;
      chk({name, "_rst_result"}, ci.result, 32'd0);
      chk({name, "_rst_done"}, {31'd0, ci.done}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      void'(sb.pop_front());
      return;
    end
    if (!ok) begin
      chk({name, "_timeout"}, 32'(cyc), 32'(lat));
      void'(sb.pop_front());
      return;
    end
    got = ci.result;
    chk({name, "_result"}, got, sb.pop_front());
    chk({name, "_latency"}, 32'(cyc), 32'(lat));
    @(negedge clk); #1;
    chk({name, "_done_1cyc"}, {31'd0, ci.done}, 32'd0);
    chk({name, "_hold"}, ci.result, got);
  endtask

  initial begin
    vec_t        tbl[$];
    logic [31:0] got, last;
    n_chk = 0; n_pass = 0;
    model_reset();
    reset = 1'b1;
    ci.clk_en = 1'b1; ci.start = 1'b0; ci.n = 2'd0; ci.dataa = '0; ci.datab = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_result", ci.result, 32'd0);
    chk("reset_done", {31'd0, ci.done}, 32'd0);
    reset = 1'b0;

    tbl.push_back('{OP_READ_TAP,  32'd0,          32'd0,  32'h0000_0000, 1});
    tbl.push_back('{OP_READ_TAP,  32'd0,          32'd31, 32'h0000_0000, 1});
    tbl.push_back('{OP_FILTER,    32'd0,          32'd0,  32'h0000_0000, 34});
    tbl.push_back('{OP_LOAD_COEF, 32'h4000,       32'd0,  32'h0000_0000, 1});
    tbl.push_back('{OP_FILTER,    32'd1000,       32'd0,  32'h0000_01F4, 34});
    tbl.push_back('{OP_READ_TAP,  32'd0,          32'd32, 32'd1000,      1});
    tbl.push_back('{OP_READ_TAP,  32'd0,          32'd1,  32'h0000_0000, 1});
    tbl.push_back('{OP_LOAD_COEF, 32'd0,          32'd0,  32'h0000_0000, 1});
    tbl.push_back('{OP_LOAD_COEF, 32'hFFFF_7FFF,  32'd3,  32'h0000_0000, 1});
    tbl.push_back('{OP_CLEAR,     32'd0,          32'd0,  32'h0000_0000, 1});
    tbl.push_back('{OP_FILTER,    32'hABCD_4000,  32'd0,  32'h0000_0000, 34});
    tbl.push_back('{OP_FILTER,    32'd0,          32'd0,  32'h0000_0000, 34});
    tbl.push_back('{OP_FILTER,    32'd0,          32'd0,  32'h0000_0000, 34});
    tbl.push_back('{OP_FILTER,    32'd0,          32'd0,  32'h0000_4000, 34});
    tbl.push_back('{OP_READ_TAP,  32'd0,          32'd3,  32'h0000_4000, 1});
    tbl.push_back('{OP_READ_TAP,  32'd0,          32'd0,  32'h0000_0000, 1});
    foreach (tbl[i])
      issue($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp, 1'b0,
            tbl[i].lat, got, -1, 0, -1, -1);

    // Saturation on both rails.
    for (int i = 0; i < 32; i++)
      issue("coef_max", OP_LOAD_COEF, 32'h7FFF, 32'(i), 32'd0, 1'b1, 1, got, -1, 0, -1, -1);
    last = '0;
    for (int i = 0; i < 32; i++) begin
      issue("sat_pos", OP_FILTER, 32'h7FFF, 32'd0, 32'd0, 1'b1, 34, got, -1, 0, -1, -1);
      last = got;
    end
    chk("sat_pos_final", last, 32'h0000_7FFF);
    for (int i = 0; i < 32; i++) begin
      issue("sat_neg", OP_FILTER, 32'h8000, 32'd0, 32'd0, 1'b1, 34, got, -1, 0, -1, -1);
      last = got;
    end
    chk("sat_neg_final", last, 32'hFFFF_8000);
    issue("read_neg", OP_READ_TAP, 32'd0, 32'd5, 32'hFFFF_8000, 1'b0, 1, got, -1, 0, -1, -1);

    // Stall mid-MAC: same result as the unstalled run, done 5 cycles later;
    // a CLEAR started while busy must be ignored.
    issue("clr_a", OP_CLEAR, 32'd0, 32'd0, 32'd0, 1'b0, 1, got, -1, 0, -1, -1);
    issue("flt_ref", OP_FILTER, 32'd1000, 32'd0, 32'd1000, 1'b0, 34, got, -1, 0, -1, -1);
    issue("clr_b", OP_CLEAR, 32'd0, 32'd0, 32'd0, 1'b0, 1, got, -1, 0, -1, -1);
    issue("flt_stall", OP_FILTER, 32'd1000, 32'd0, 32'd1000, 1'b0, 39, got, 10, 5, 20, -1);
    idle(3);
    issue("busy_ign", OP_READ_TAP, 32'd0, 32'd0, 32'd1000, 1'b0, 1, got, -1, 0, -1, -1);
    issue("rd_stall", OP_READ_TAP, 32'd0, 32'd0, 32'd1000, 1'b0, 6, got, 1, 5, -1, -1);

    // Reset in the middle of MAC: nothing completes, state fully cleared.
    issue("abort", OP_FILTER, 32'd500, 32'd0, 32'd0, 1'b0, 34, got, -1, 0, -1, 10);
    idle(40);
    issue("rst_tap0", OP_READ_TAP, 32'd0, 32'd0, 32'd0, 1'b0, 1, got, -1, 0, -1, -1);
    issue("rst_tap31", OP_READ_TAP, 32'd0, 32'd31, 32'd0, 1'b0, 1, got, -1, 0, -1, -1);
    issue("rst_coef", OP_FILTER, 32'd2000, 32'd0, 32'd0, 1'b0, 34, got, -1, 0, -1, -1);
    issue("ld0", OP_LOAD_COEF, 32'h4000, 32'd0, 32'd0, 1'b0, 1, got, -1, 0, -1, -1);
    issue("ld1", OP_LOAD_COEF, 32'h4000, 32'd1, 32'd0, 1'b0, 1, got, -1, 0, -1, -1);
    issue("post_rst", OP_FILTER, 32'd3000, 32'd0, 32'd2500, 1'b0, 34, got, -1, 0, -1, -1);
    issue("neg_round", OP_FILTER, 32'hFFFF_FFFD, 32'd0, 32'd0, 1'b1, 34, got, -1, 0, -1, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
